assert_time_multi: RTL

ASSERT_TIME_MULTI -- requirements
Module: assert_time_multi

---
 rtl/assert_time_multi.sv | 102 ++++++++++
 1 files changed

// File: rtl/assert_time_multi.sv
// Multi-channel timed-window checker: each start opens an NUM_CKS-cycle window
// in which test_expr must stay high; violations and overlapping starts are reported.
module assert_time_multi #(
  parameter int unsigned NUM_CH              = 4,
  parameter int unsigned NUM_CKS             = 2,
  parameter int unsigned CNT_W               = 8,
  parameter int unsigned ACTION_ON_NEW_START = 0,
  parameter int unsigned ERR_W               = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] start_event,
  input  logic [NUM_CH-1:0] test_expr,
  output logic [NUM_CH-1:0] window_open,
  output logic [NUM_CH-1:0] fire_test,
  output logic [NUM_CH-1:0] fire_new_start,
  output logic [NUM_CH-1:0] cover_window_close,
  output logic [NUM_CH-1:0] cover_window_reset,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned     SUM_W   = ERR_W + 8;
  localparam int unsigned     ACT_RST = 1;
  localparam int unsigned     ACT_ERR = 2;
  localparam logic [CNT_W-1:0] LOAD   = CNT_W'(NUM_CKS);
  localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'({ERR_W{1'b1}});

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] window_open_q, window_open_d;
  logic [NUM_CH-1:0] fire_test_q, fire_test_d;
  logic [NUM_CH-1:0] fire_new_start_q, fire_new_start_d;
  logic [NUM_CH-1:0] cover_close_q, cover_close_d;
  logic [NUM_CH-1:0] cover_reset_q, cover_reset_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [SUM_W-1:0]  err_sum;

  // Per-channel window counters and next-cycle event pulses
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]            = cnt_q[i];
      fire_test_d[i]      = 1'b0;
      fire_new_start_d[i] = 1'b0;
      cover_close_d[i]    = 1'b0;
      cover_reset_d[i]    = 1'b0;
      if (cnt_q[i] != '0) begin
        fire_test_d[i] = enable & ~test_expr[i];
        if (ACTION_ON_NEW_START == ACT_ERR) begin
          fire_new_start_d[i] = enable & start_event[i];
        end
        if ((ACTION_ON_NEW_START == ACT_RST) && enable && start_event[i]) begin
          cnt_d[i]         = LOAD;
          cover_reset_d[i] = 1'b1;
        end else begin
          cnt_d[i]         = cnt_q[i] - CNT_W'(1);
          cover_close_d[i] = (cnt_q[i] == CNT_W'(1));
        end
      end else if (enable && start_event[i]) begin
        cnt_d[i] = LOAD;
      end
      window_open_d[i] = (cnt_d[i] != '0);
    end
  end

  // Saturating accumulation of every fire bit raised this cycle
  always_comb begin
    err_sum = SUM_W'(err_count_q);
    for (int i = 0; i < NUM_CH; i++) begin
      err_sum = err_sum + SUM_W'(fire_test_d[i]) + SUM_W'(fire_new_start_d[i]);
    end
    err_count_d = (err_sum > ERR_MAX) ? ERR_W'(ERR_MAX) : ERR_W'(err_sum);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      window_open_q    <= '0;
      fire_test_q      <= '0;
      fire_new_start_q <= '0;
      cover_close_q    <= '0;
      cover_reset_q    <= '0;
      err_count_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      window_open_q    <= window_open_d;
      fire_test_q      <= fire_test_d;
      fire_new_start_q <= fire_new_start_d;
      cover_close_q    <= cover_close_d;
      cover_reset_q    <= cover_reset_d;
      err_count_q      <= err_count_d;
    end
  end

  assign window_open        = window_open_q;
  assign fire_test          = fire_test_q;
  assign fire_new_start     = fire_new_start_q;
  assign cover_window_close = cover_close_q;
  assign cover_window_reset = cover_reset_q;
  assign err_count          = err_count_q;

endmodule
